alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 16-bit ALU slice-chain between two requesters using valid/ready handshakes.
- Grants round-robin, registers the winner's operands onto the ALU inputs and captures the result. Returns the result and carry-out to the granted requester.
- Sits between the two datapath clients (e.g. address-gen and execute) and the single `alu` instance. One operation is in flight at a time.

Parameters:
- WIDTH, 16: operand/result width; must match the ALU width.
- CNT_W, 16: width of the optional grant counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: arbiter accepts requester i this cycle
- req_op  in  4  op for requester i at [2i+1:2i]
- req_a  in  2*WIDTH  operand a for requester i at [WIDTH*i +: WIDTH]
- req_b  in  2*WIDTH  operand b, same packing
- rsp_valid  out  2  bit i: result for requester i available
- rsp_ready  in  2  bit i: requester i takes the result
- rsp_data  out  WIDTH  result, shared by both requesters; qualified by rsp_valid
- rsp_cout  out  1  carry-out of the result
- alu_op  out  2  to ALU op
- alu_i0  out  WIDTH  to ALU i0
- alu_i1  out  WIDTH  to ALU i1
- alu_o  in  WIDTH  from ALU o
- alu_cout  in  1  from ALU cout

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE
  - alu_op/alu_i0/alu_i1=0
  - rsp_valid=0, rsp_data=0, rsp_cout=0
  - last_grant=1, so requester 0 wins the first contention
  - counters=0
- Reset mid-operation discards the in-flight op; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready[i] = req_valid[i] && (i is the winner); at most one bit is set. req_ready is 0 in EXEC/RESP.
  - Winner: the only valid requester, or, when both are valid, the requester not equal to last_grant.
  - On handshake: latch op/a/b into alu_op/alu_i0/alu_i1, set gnt_id=winner, last_grant=winner, go to EXEC.
  - No valid requester: stay in IDLE and hold the ALU output registers.
- EXEC (exactly 1 cycle):
  - The ALU evaluates the registered inputs combinationally.
  - At the edge: rsp_data<=alu_o, rsp_cout<=alu_cout, go to RESP.
- RESP:
  - rsp_valid[gnt_id]=1, other bit 0; rsp_data/rsp_cout held stable.
  - Stays until rsp_ready[gnt_id]=1, then IDLE. rsp_ready of the non-granted requester is ignored.
- Latency:
  - Accept edge N; rsp_valid asserted from cycle N+2.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with immediate rsp_ready).
- ALU inputs stay registered and stable from accept until the next accept. No combinational path exists from req_* to alu_*.
- Arithmetic is done entirely by the ALU. The arbiter never modifies op or operands. The carry/borrow is the ALU's cout, unmodified.
- Requester deasserting req_valid before handshake: allowed, nothing is consumed. Changing payload while valid and not ready is allowed.
- Simultaneous req_valid=2'b11 with last_grant=0 grants 1; with last_grant=1 grants 0. Strict alternation is kept under continuous contention.

Optional Feature:
- Macro ALU_ARB_STATS_EN. With it defined, two extra outputs exist:
  - gnt_cnt0 [CNT_W-1:0] and gnt_cnt1 [CNT_W-1:0].
  - Each increments on every accept of its requester and saturates at all-ones; reset clears them.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - ALU op constants ALU_ADD=2'b00, ALU_SUB=2'b01 (op[0] is the carry-in);
  - N_REQ=2.
- One sub-module, rr_pick2: pure combinational round-robin winner select from req_valid[1:0] and last_grant, giving the winner id and any-valid.
- The `alu` datapath is instantiated at the parent level, not inside this block.

Test Plan:
- Single request: r0 op=ALU_ADD, a=16'h0003, b=16'h0004 -> alu_i0/i1 registered next cycle; rsp_valid=2'b01, rsp_data=16'h0007, rsp_cout=0 at N+2.
- Carry: r1 ALU_ADD, a=16'hFFFF, b=16'h0001 -> rsp_valid=2'b10, rsp_data=16'h0000, rsp_cout=1.
- Contention after reset: req_valid=2'b11 held for 4 ops -> grant order 0,1,0,1; each response tagged to the correct rsp_valid bit.
- Backpressure: rsp_ready[0]=0 for 5 cycles during RESP -> rsp_data stable, req_ready=0 throughout, r1 waits; release -> r1 accepted in the following IDLE cycle.
- Async reset asserted in EXEC -> outputs zero immediately (same cycle, no clock edge); no rsp_valid after release; next request completes normally.
- ALU_ARB_STATS_EN with CNT_W=2: 5 accepts from r0 -> gnt_cnt0 saturates at 2'b11, gnt_cnt1=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding,
// ALU op codes (op[0] doubles as the ALU carry-in) and the requester count.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  localparam int N_REQ = 2;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational round-robin winner select for two requesters.
// A lone valid requester always wins. Under contention the requester that
// did not win last time wins, giving strict alternation.
module rr_pick2
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic             last_grant,
  output logic             winner,
  output logic             any_valid
);

  // Pick the winner id and flag whether anyone is asking at all
  always_comb begin
    any_valid = |valid;
    if (valid == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = valid[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter in front of one shared combinational ALU.
// Operands of the round-robin winner are registered onto the ALU inputs, the
// ALU result is captured one cycle later and returned to the granted client.
// Optional grant statistics are enabled with the macro ALU_ARB_STATS_EN,
// which adds the saturating outputs gnt_cnt0 and gnt_cnt1.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_cout,
  output logic [1:0]           alu_op,
  output logic [WIDTH-1:0]     alu_i0,
  output logic [WIDTH-1:0]     alu_i1,
  input  logic [WIDTH-1:0]     alu_o,
  input  logic                 alu_cout
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]     gnt_cnt0,
  output logic [CNT_W-1:0]     gnt_cnt1
`endif
);

  // A zero-width counter makes no sense even when statistics are compiled out
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("alu_arbiter: CNT_W must be at least 1");
  end

  state_t state;
  state_t state_nxt;
  logic   winner;
  logic   any_valid;
  logic   gnt_id;
  logic   last_grant;
  logic   accept;

  rr_pick2 u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  assign accept = (state == IDLE) && any_valid;

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: one EXEC cycle, then hold RESP until the granted client takes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[gnt_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: ready only to the IDLE winner, response only to the grantee
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && any_valid) begin
      req_ready[winner] = 1'b1;
    end
    if (state == RESP) begin
      rsp_valid[gnt_id] = 1'b1;
    end
  end

  // Register the winner's op and operands; they stay put until the next accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op     <= '0;
      alu_i0     <= '0;
      alu_i1     <= '0;
      gnt_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_op     <= req_op[2*winner +: 2];
      alu_i0     <= req_a[WIDTH*winner +: WIDTH];
      alu_i1     <= req_b[WIDTH*winner +: WIDTH];
      gnt_id     <= winner;
      last_grant <= winner;
    end
  end

  // Capture the ALU result and carry at the end of the EXEC cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_cout <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= alu_o;
      rsp_cout <= alu_cout;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester accept counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (!winner && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (winner && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter. A small behavioural ALU
// (add, or subtract when op[0] is set) closes the loop on alu_* ports.
// Define ALU_ARB_STATS_EN to also exercise the saturating grant counters.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 2;

  logic               clk;
  logic               reset;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_cout;
  logic [1:0]         alu_op;
  logic [WIDTH-1:0]   alu_i0;
  logic [WIDTH-1:0]   alu_i1;
  logic [WIDTH-1:0]   alu_o;
  logic               alu_cout;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0]   gnt_cnt0;
  logic [CNT_W-1:0]   gnt_cnt1;
`endif

  int checkCount = 0;
  int failCount  = 0;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .alu_op    (alu_op),
    .alu_i0    (alu_i0),
    .alu_i1    (alu_i1),
    .alu_o     (alu_o),
    .alu_cout  (alu_cout)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  // Behavioural stand-in for the shared ALU: a + (op[0] ? ~b : b) + op[0]
  logic [WIDTH:0] aluSum;
  assign aluSum   = {1'b0, alu_i0} + {1'b0, (alu_op[0] ? ~alu_i1 : alu_i1)} + {{WIDTH{1'b0}}, alu_op[0]};
  assign alu_o    = aluSum[WIDTH-1:0];
  assign alu_cout = aluSum[WIDTH];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one requester's valid and payload slots
  task automatic applyStimulus(input int id, input logic valid, input logic [1:0] op,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[id]           = valid;
    req_op[2*id +: 2]       = op;
    req_a[WIDTH*id +: WIDTH] = a;
    req_b[WIDTH*id +: WIDTH] = b;
  endtask

  // Synchronous-looking reset pulse between tests
  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete transaction from a lone requester, checked at every stage
  task automatic doSingle(input int id, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expData,
                          input logic expCout);
    logic [1:0] expOneHot;
    int n;
    expOneHot     = 2'b00;
    expOneHot[id] = 1'b1;
    @(negedge clk);
    applyStimulus(id, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!req_ready[id] && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("single_req_ready", {30'b0, req_ready}, {30'b0, expOneHot});
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    checkOutput("single_alu_op", {30'b0, alu_op}, {30'b0, op});
    checkOutput("single_alu_i0", {16'b0, alu_i0}, {16'b0, a});
    checkOutput("single_alu_i1", {16'b0, alu_i1}, {16'b0, b});
    @(negedge clk);
    #1;
    checkOutput("single_rsp_valid", {30'b0, rsp_valid}, {30'b0, expOneHot});
    checkOutput("single_rsp_data", {16'b0, rsp_data}, {16'b0, expData});
    checkOutput("single_rsp_cout", {31'b0, rsp_cout}, {31'b0, expCout});
    rsp_ready[id] = 1'b1;
    @(negedge clk);
    rsp_ready[id] = 1'b0;
    #1;
    checkOutput("single_rsp_done", {30'b0, rsp_valid}, 32'd0);
  endtask

  // Directed test sequence
  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    #12;
    #1;
    checkOutput("reset_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    checkOutput("reset_req_ready", {30'b0, req_ready}, 32'd0);
    checkOutput("reset_alu_i0", {16'b0, alu_i0}, 32'd0);
    checkOutput("reset_rsp_data", {16'b0, rsp_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single add from r0, then an add with carry-out from r1
    doSingle(0, ALU_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    doSingle(1, ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);

    // Contention from reset: both valid for four ops, expect 0,1,0,1
    pulseReset();
    @(negedge clk);
    applyStimulus(0, 1'b1, ALU_ADD, 16'h0001, 16'h0001);
    applyStimulus(1, 1'b1, ALU_SUB, 16'h000A, 16'h0003);
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 12; k++) begin
      int g;
      g = (k / 3) % 2;
      case (k % 3)
        0: checkOutput("cont_req_ready", {30'b0, req_ready}, (g == 1) ? 32'd2 : 32'd1);
        1: begin
          checkOutput("cont_alu_i0", {16'b0, alu_i0}, (g == 1) ? 32'h000A : 32'h0001);
          checkOutput("cont_alu_op", {30'b0, alu_op}, (g == 1) ? 32'd1 : 32'd0);
        end
        default: begin
          checkOutput("cont_rsp_valid", {30'b0, rsp_valid}, (g == 1) ? 32'd2 : 32'd1);
          checkOutput("cont_rsp_data", {16'b0, rsp_data}, (g == 1) ? 32'h0007 : 32'h0002);
          checkOutput("cont_rsp_cout", {31'b0, rsp_cout}, (g == 1) ? 32'd1 : 32'd0);
        end
      endcase
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Backpressure on r0's response while r1 waits; r1's rsp_ready is ignored
    @(negedge clk);
    applyStimulus(0, 1'b1, ALU_ADD, 16'h1234, 16'h1111);
    #1;
    checkOutput("bp_r0_ready", {30'b0, req_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 1'b0, ALU_ADD, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b1, ALU_SUB, 16'h0005, 16'h0007);
    rsp_ready = 2'b10;
    #1;
    checkOutput("bp_exec_ready", {30'b0, req_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_rsp_valid", {30'b0, rsp_valid}, 32'd1);
      checkOutput("bp_rsp_data", {16'b0, rsp_data}, 32'h2345);
      checkOutput("bp_req_ready", {30'b0, req_ready}, 32'd0);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    checkOutput("bp_r1_ready", {30'b0, req_ready}, 32'd2);
    checkOutput("bp_idle_rsp", {30'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("bp_r1_alu_i0", {16'b0, alu_i0}, 32'h0005);
    @(negedge clk);
    #1;
    checkOutput("bp_r1_rsp_valid", {30'b0, rsp_valid}, 32'd2);
    checkOutput("bp_r1_rsp_data", {16'b0, rsp_data}, 32'hFFFE);
    checkOutput("bp_r1_rsp_cout", {31'b0, rsp_cout}, 32'd0);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;

    // Asynchronous reset during EXEC clears outputs without a clock edge
    @(negedge clk);
    applyStimulus(0, 1'b1, ALU_SUB, 16'h0005, 16'h0006);
    #1;
    checkOutput("ar_req_ready", {30'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("ar_exec_i0", {16'b0, alu_i0}, 32'h0005);
    reset = 1'b1;
    #1;
    checkOutput("ar_alu_op", {30'b0, alu_op}, 32'd0);
    checkOutput("ar_alu_i0", {16'b0, alu_i0}, 32'd0);
    checkOutput("ar_alu_i1", {16'b0, alu_i1}, 32'd0);
    checkOutput("ar_rsp_data", {16'b0, rsp_data}, 32'd0);
    checkOutput("ar_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput("ar_no_rsp", {30'b0, rsp_valid}, 32'd0);
    end
    doSingle(0, ALU_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);

`ifdef ALU_ARB_STATS_EN
    // Grant counter saturation with a 2-bit counter
    pulseReset();
    #1;
    checkOutput("stats_reset_cnt0", {30'b0, gnt_cnt0}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      doSingle(0, ALU_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    end
    checkOutput("stats_cnt0_sat", {30'b0, gnt_cnt0}, 32'd3);
    checkOutput("stats_cnt1_zero", {30'b0, gnt_cnt1}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
